paralelo_serial_tx: RTL and testbench
=====================================

# paralelo_serial_tx

Byte-to-bit serializer that sits directly downstream of the 2:1 byte mux stage. It accepts 8-bit words with a valid/ready handshake, buffers them in a small FIFO and shifts them out MSB-first on a single serial line. Idle frames and a post-reset alignment preamble carry the COM character, so the receiving serial-to-parallel stage can lock onto frame boundaries.

## Interface

Parameters:
- COM_CHAR, 8'hBC: idle/alignment symbol.
- SYNC_FRAMES, 4: COM frames forced after reset release before data may be sent.
- FIFO_DEPTH, 2: input buffer entries; power of two, at least 2.

Ports:
- clk_32f  in  1  bit clock; one serial bit per rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- data_in  in  8  byte from the mux stage.
- valid_in  in  1  data_in is valid this cycle.
- ready_out  out  1  FIFO can accept a byte; equals !full.
- serial_out  out  1  serial bit, MSB of the shift register.
- frame_start  out  1  high during bit 7 (first bit) of every frame.
- data_frame  out  1  high for all 8 cycles of a frame carrying FIFO data, low for COM frames.
- sync_done  out  1  high once the SYNC preamble has completed.

## Operation

- Push: on a rising edge with valid_in=1 and ready_out=1, data_in is written to the FIFO. valid_in while ready_out=0 is ignored and the byte is dropped. The upstream stage sends no retries.
- Frame: 3-bit bit_cnt runs 0..7 continuously. Shift register shreg[7:0] shifts left by 1 each cycle, and serial_out = shreg[7]. A boundary is a cycle with bit_cnt==7. On the next edge, shreg loads the next frame's byte and bit_cnt wraps to 0.
- FSM states:
  - SYNC: every boundary loads COM_CHAR and increments sync_cnt. When sync_cnt reaches SYNC_FRAMES-1 at a boundary, the state moves to ACTIVE on that edge. The load decision at that same edge already uses the ACTIVE rule.
  - ACTIVE: at a boundary, if the FIFO is non-empty, pop its head into shreg and set data_frame=1. Otherwise load COM_CHAR and set data_frame=0.
  - No transition leaves ACTIVE except reset.
- FIFO accepts pushes in both states, so bytes can queue during SYNC.
- Simultaneous push and pop at the same edge: both take effect and the count is unchanged. When the FIFO is full, ready_out=0, so a push cannot coincide with a full-state pop. ready_out rises the cycle after the pop.
- Pointer wrap: the read and write pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Reset mid-frame: the partial frame is abandoned and the FIFO contents are discarded. All outputs return to their reset values asynchronously.
- Reset values:
  - shreg=COM_CHAR, so serial_out=1.
  - bit_cnt=0, frame_start=1.
  - State SYNC, sync_cnt=0, sync_done=0.
  - data_frame=0.
  - FIFO empty, ready_out=1.

## Timing

- The frame loaded at reset counts as SYNC frame 0. Frames 0..SYNC_FRAMES-1 are COM; with defaults these are cycles 0–31 after reset release.
- sync_done rises at cycle 8·SYNC_FRAMES (32). The earliest data bit is also at cycle 32, provided the FIFO held a byte by cycle 31.
- Push-to-first-bit latency in ACTIVE with an empty FIFO: from 1 cycle (push at bit_cnt==7 loads on the next edge) up to 8 cycles.
- Sustained throughput is one byte per 8 cycles. Upstream valid duty must stay at or below 1/8 on average, with bursts no longer than FIFO_DEPTH bytes.
- frame_start and data_frame are registered and aligned with serial_out.

## Structure

- Shared package `serdes_pkg`: COM_CHAR value, SYNC_FRAMES default, and the state enum (SYNC, ACTIVE), shared with the serial-to-parallel receiver.
- Sub-module `fifo_byte`: a parameterized synchronous FIFO with push/pop/full/empty/head, reset active-low and asynchronous. The serializer FSM and shifter stay in the top module.

## Test plan

- Reset, no traffic: serial_out repeats 1,0,1,1,1,1,0,0 continuously. sync_done=0 until cycle 32 and 1 after. data_frame stays 0.
- Single byte 8'hA5 pushed at cycle 40: the frame starting at cycle 48 carries 1,0,1,0,0,1,0,1 with data_frame=1. The frame at cycle 56 returns to COM.
- Bytes 8'h11, 8'h22, 8'h33 pushed on cycles 10–12, during SYNC:
  - 11 and 22 are accepted; ready_out=0 at cycle 12, so 33 is dropped.
  - Output is 4 COM frames, then 11, then 22, then COM.
- Push 8'h5A exactly at a bit_cnt==7 cycle in ACTIVE with an empty FIFO: it is serialized starting the very next cycle.
- Full FIFO with a pop: ready_out rises one cycle after the boundary. A push on that cycle succeeds, and the count goes 2→1→2.
- Reset asserted mid-frame at bit 3 of 8'hF0 with one byte queued:
  - serial_out=1 and frame_start=1 immediately; ready_out=1.
  - After release, 4 COM frames follow and the queued byte is never sent.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared serdes definitions: COM symbol, preamble length, link state.
// Also imported by the serial-to-parallel receiver.
package serdes_pkg;

  localparam logic [7:0] COM_CHAR_DEF = 8'hBC;
  localparam int SYNC_FRAMES_DEF = 4;

  typedef enum logic {
    SYNC,
    ACTIVE
  } tx_state_t;

endpackage

// File: rtl/fifo_byte.sv
// Small synchronous byte FIFO, power-of-two depth.
// Head is always visible; pop and push may share an edge.
module fifo_byte #(
  parameter int DEPTH = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte-to-bit serializer, MSB first, with COM idle frames
// and a post-reset COM alignment preamble.
module paralelo_serial_tx
  import serdes_pkg::*;
#(
  parameter logic [7:0] COM_CHAR = COM_CHAR_DEF,
  parameter int SYNC_FRAMES = SYNC_FRAMES_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out,
  output logic       frame_start,
  output logic       data_frame,
  output logic       sync_done
);

  tx_state_t state;
  tx_state_t state_nxt;

  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] sync_cnt;
  logic       fs_q;
  logic       df_q;

  logic       boundary;
  logic       sync_last;
  logic       use_active;
  logic       push_ok;
  logic       pop;
  logic       bypass;
  logic       fifo_push;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic [7:0] ld_byte;

  assign boundary  = (bit_cnt == 3'd7);
  assign push_ok   = valid_in & ready_out;
  assign sync_last = (state == SYNC) &&
                     (sync_cnt == 8'(SYNC_FRAMES - 1));

  fifo_byte #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_32f),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (data_in),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (boundary && sync_last) state_nxt = ACTIVE;
  end

  // Last preamble boundary already follows the ACTIVE load rule.
  // An empty FIFO pushed on a boundary hands data_in straight over.
  always_comb begin
    use_active = (state == ACTIVE) || sync_last;
    pop        = boundary & use_active & ~fifo_empty;
    bypass     = boundary & use_active & fifo_empty & push_ok;
    fifo_push  = push_ok & ~bypass;
    ld_byte    = COM_CHAR;
    unique case (1'b1)
      pop:     ld_byte = head;
      bypass:  ld_byte = data_in;
      default: ld_byte = COM_CHAR;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= 3'd0;
      shreg    <= COM_CHAR;
      sync_cnt <= 8'd0;
      fs_q     <= 1'b1;
      df_q     <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      fs_q    <= boundary;
      if (boundary) begin
        shreg <= ld_byte;
        df_q  <= pop | bypass;
        if (state == SYNC) sync_cnt <= sync_cnt + 8'd1;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

  assign ready_out   = ~fifo_full;
  assign serial_out  = shreg[7];
  assign frame_start = fs_q;
  assign data_frame  = df_q;
  assign sync_done   = (state == ACTIVE);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: per-cycle checks against
// hand-built frame, push and ready tables.
module tb_paralelo_serial_tx;

  localparam logic [7:0] COM = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       serial_out;
  logic       frame_start;
  logic       data_frame;
  logic       sync_done;

  int total = 0;
  int bad = 0;
  int cur = 0;
  int cur_sc = 0;

  typedef struct {
    int         sc;
    int         cyc;
    logic [7:0] d;
  } push_t;

  typedef struct {
    int         sc;
    int         start;
    logic [7:0] b;
  } frame_t;

  typedef struct {
    int   sc;
    int   cyc;
    logic r;
  } rdy_t;

  push_t  pq[$];
  frame_t fq[$];
  rdy_t   rq[$];

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_tx dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .serial_out  (serial_out),
    .frame_start (frame_start),
    .data_frame  (data_frame),
    .sync_done   (sync_done)
  );

  task automatic chk(string nm, logic a, logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s sc=%0d cyc=%0d got=%b want=%b",
               nm, cur_sc, cur, a, e);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_32f);
    valid_in = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_sc(int sc, int ncyc);
    logic [7:0] eb;
    logic       edf;
    cur_sc = sc;
    for (int c = 0; c < ncyc; c++) begin
      cur = c;
      eb  = COM;
      edf = 1'b0;
      foreach (fq[i])
        if (fq[i].sc == sc && c >= fq[i].start &&
            c < fq[i].start + 8) begin
          eb  = fq[i].b;
          edf = 1'b1;
        end
      chk("serial_out", serial_out, eb[7 - (c % 8)]);
      chk("frame_start", frame_start, (c % 8) == 0);
      chk("data_frame", data_frame, edf);
      chk("sync_done", sync_done, c >= 32);
      foreach (rq[i])
        if (rq[i].sc == sc && rq[i].cyc == c)
          chk("ready_out", ready_out, rq[i].r);
      valid_in = 1'b0;
      foreach (pq[i])
        if (pq[i].sc == sc && pq[i].cyc == c) begin
          valid_in = 1'b1;
          data_in  = pq[i].d;
        end
      @(negedge clk_32f);
      #1;
    end
    valid_in = 1'b0;
  endtask

  initial begin
    pq.push_back('{2, 40, 8'hA5});
    pq.push_back('{3, 10, 8'h11});
    pq.push_back('{3, 11, 8'h22});
    pq.push_back('{3, 12, 8'h33});
    pq.push_back('{4, 39, 8'h5A});
    pq.push_back('{5, 41, 8'h61});
    pq.push_back('{5, 42, 8'h62});
    pq.push_back('{5, 45, 8'hEE});
    pq.push_back('{5, 48, 8'h63});
    pq.push_back('{6, 39, 8'hF0});
    pq.push_back('{6, 40, 8'h77});

    fq.push_back('{2, 48, 8'hA5});
    fq.push_back('{3, 32, 8'h11});
    fq.push_back('{3, 40, 8'h22});
    fq.push_back('{4, 40, 8'h5A});
    fq.push_back('{5, 48, 8'h61});
    fq.push_back('{5, 56, 8'h62});
    fq.push_back('{5, 64, 8'h63});
    fq.push_back('{6, 40, 8'hF0});

    rq.push_back('{1, 0, 1'b1});
    rq.push_back('{3, 11, 1'b1});
    rq.push_back('{3, 12, 1'b0});
    rq.push_back('{3, 31, 1'b0});
    rq.push_back('{3, 32, 1'b1});
    rq.push_back('{4, 39, 1'b1});
    rq.push_back('{4, 40, 1'b1});
    rq.push_back('{5, 43, 1'b0});
    rq.push_back('{5, 47, 1'b0});
    rq.push_back('{5, 48, 1'b1});
    rq.push_back('{5, 49, 1'b0});
    rq.push_back('{5, 56, 1'b1});

    apply_reset();
    run_sc(1, 64);
    apply_reset();
    run_sc(2, 72);
    apply_reset();
    run_sc(3, 56);
    apply_reset();
    run_sc(4, 56);
    apply_reset();
    run_sc(5, 80);

    // Reset in the middle of an F0 frame with 77 still queued
    apply_reset();
    run_sc(6, 44);
    cur_sc = 6;
    cur = 44;
    chk("pre_rst_serial", serial_out, 1'b0);
    chk("pre_rst_fs", frame_start, 1'b0);
    chk("pre_rst_df", data_frame, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_fs", frame_start, 1'b1);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_df", data_frame, 1'b0);
    chk("rst_sync", sync_done, 1'b0);
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
    #1;
    run_sc(7, 56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
